// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell used to build the ripple adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of one bit position.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder: a chain of full-adder cells, carry-in tied low.
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake.
// One WIDTH-bit ripple adder is reused for WIDTH cycles per product.
// Optional build macro MULT_ZERO_SKIP_EN: a zero operand finishes in one edge
// (straight to DONE with P=0, Busy never asserted).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on the accepting edge
// ST_RUN  | one add/shift step per edge, cnt counts remaining steps down
// ST_DONE | product valid on p, done pulses for this single cycle
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   acc;
    logic [CNT_W-1:0] cnt;

    logic             load;
    logic             step;
    logic             finish;
    logic             skip;
    logic             zero_op;

    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   acc_shift;
    logic [WIDTH-1:0] q_shift;

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (acc[WIDTH-1:0]),
        .b    (m),
        .sum  (sum),
        .cout (cout)
    );

    // Conditional add of the multiplicand, then one right shift of {acc, q}.
    // The carry lands in acc[WIDTH] and is shifted down on the same step.
    always_comb begin
        acc_sum   = q[0] ? {cout, sum} : acc;
        acc_shift = {1'b0, acc_sum[WIDTH:1]};
        q_shift   = {acc_sum[0], q[WIDTH-1:1]};
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        skip       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (zero_op) begin
                        skip       = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        load       = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == ST_RUN);
            done  <= (state_next == ST_DONE);
        end
    end

    // Operand capture, add/shift iteration and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m   <= '0;
            q   <= '0;
            acc <= '0;
            cnt <= '0;
            p   <= '0;
        end else begin
            if (load) begin
                m   <= a;
                q   <= b;
                acc <= '0;
                cnt <= CNT_W'(WIDTH);
            end else if (step) begin
                acc <= acc_shift;
                q   <= q_shift;
                cnt <= cnt - CNT_W'(1);
            end
            if (finish) begin
                p <= {acc_shift[WIDTH-1:0], q_shift};
            end else if (skip) begin
                p <= '0;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: the driver pushes the expected
// product, done time and busy length per accepted operation; a negedge monitor
// pops and compares whenever done is seen, and also checks p holds between.
module tb_shift_add_mult_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
        int             busy;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int             cyc = 0;
    int             vectors = 0;
    int             miscompares = 0;
    int             next_ok = 0;
    int             busy_count = 0;
    logic [2*W-1:0] hold_p = '0;
    exp_t           sb[$];

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int prod;
        prod = int'(x) * int'(y);
        return prod[2*W-1:0];
    endfunction

    function automatic bit is_skip(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULT_ZERO_SKIP_EN
        return (x == '0) || (y == '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Record the expectation for an operation accepted on edge t0.
    task automatic expect_op(input logic [W-1:0] x, input logic [W-1:0] y, input int t0);
        exp_t e;
        e.p    = ref_mul(x, y);
        e.cyc  = is_skip(x, y) ? t0 : t0 + W;
        e.busy = is_skip(x, y) ? 0 : W;
        sb.push_back(e);
        next_ok = is_skip(x, y) ? t0 + 1 : t0 + W + 1;
    endtask

    // Single-cycle start pulse once the DUT is known to be idle; returns at the
    // negedge following the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        while (cyc < next_ok) @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        expect_op(x, y, cyc + 1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compares on done, checks p is held otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_count = 0;
            hold_p     = '0;
        end else begin
            if (busy && done) check("busy_and_done", 32'd1, 32'd0);
            if (busy) busy_count++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("product", 32'(p), 32'(e.p));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("busy_cycles", 32'(busy_count), 32'(e.busy));
                    hold_p = e.p;
                end
                busy_count = 0;
            end else begin
                check("p_hold", 32'(p), 32'(hold_p));
            end
        end
    end

    logic [2*W-1:0] pairs[256];

    initial begin
        int t0;
        int k;
        logic [2*W-1:0] tmp;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_p", 32'(p), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        next_ok = cyc;

        // Full-scale operands.
        issue(4'd15, 4'd15);

        // Operands change right after acceptance.
        issue(4'd13, 4'd11);
        a = '0;
        b = '0;

        // Start re-pulsed during RUN must be ignored.
        issue(4'd6, 4'd7);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd2;
        b     = 4'd2;
        @(negedge clk);
        start = 1'b0;

        // Zero operand.
        issue(4'd0, 4'd9);
        issue(4'd9, 4'd0);

        // Start held high: two back-to-back operations.
        while (cyc < next_ok) @(negedge clk);
        a     = 4'd3;
        b     = 4'd5;
        start = 1'b1;
        t0    = cyc + 1;
        expect_op(4'd3, 4'd5, t0);
        @(negedge clk);
        a = 4'd15;
        b = 4'd1;
        t0 = next_ok + 1;
        expect_op(4'd15, 4'd1, t0);
        while (cyc < t0) @(negedge clk);
        start = 1'b0;

        // Reset mid-operation aborts with no done.
        issue(4'd7, 4'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_p", 32'(p), 32'd0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        next_ok = cyc;
        repeat (W + 4) @(negedge clk);
        next_ok = cyc;

        // All operand pairs in shuffled order with random idle gaps.
        for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            k        = int'($urandom_range(i, 0));
            tmp      = pairs[i];
            pairs[i] = pairs[k];
            pairs[k] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(2, 0)) @(negedge clk);
            issue(pairs[i][2*W-1:W], pairs[i][W-1:0]);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 4 * W + 8 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
